// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC burst capture block.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam int WD_W = 28;

  // Pointer width for a DEPTH-entry buffer; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for a slow level input plus a one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchroniser pair followed by the delay flop used for edge detection.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_pulse = s2_r & ~s3_r;

endmodule

// File: rtl/adc_burst_capture.sv
// Captures a DEPTH-sample ADC burst on sample_clk rising edges and streams it out.
// Optional capture watchdog is enabled by defining ADC_BURST_CAPTURE_TIMEOUT_EN.
module adc_burst_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              sample_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              trigger,
  input  logic              abort,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int               PTR_W    = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_t            state_r;
  state_t            next_state_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              strobe_s;
  logic              wr_en_s;
  logic              xfer_s;
  logic              arm_accept_s;
  logic              wd_expire_s;
  logic              busy_s;
  logic              rd_valid_s;
  logic              done_s;
  logic              busy_r;
  logic              rd_valid_r;
  logic              done_r;

  sync_edge_detect u_sync (
    .clock_in   (clock_in),
    .reset      (reset),
    .async_in   (sample_clk),
    .rise_pulse (strobe_s)
  );

  assign arm_accept_s = (state_r == IDLE) && arm && !abort;
  assign wr_en_s      = (state_r == CAPTURE) && strobe_s && !abort;
  assign xfer_s       = (state_r == READOUT) && rd_ready && !abort;

  // State and registered status outputs.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      busy_r     <= busy_s;
      rd_valid_r <= rd_valid_s;
      done_r     <= done_s;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    if (abort) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (arm) next_state_s = ARMED;
          else     next_state_s = IDLE;
        end
        ARMED: begin
          if (trigger) next_state_s = CAPTURE;
          else         next_state_s = ARMED;
        end
        CAPTURE: begin
          if (wd_expire_s)                            next_state_s = IDLE;
          else if (wr_en_s && (wr_ptr_r == LAST_PTR)) next_state_s = READOUT;
          else                                        next_state_s = CAPTURE;
        end
        READOUT: begin
          if (xfer_s && (rd_ptr_r == LAST_PTR)) next_state_s = IDLE;
          else                                  next_state_s = READOUT;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Next values of the status outputs, registered alongside the state.
  always_comb begin
    busy_s     = (next_state_s != IDLE);
    rd_valid_s = (next_state_s == READOUT);
    if (xfer_s && (rd_ptr_r == LAST_PTR)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Write and read pointers; both wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else if (abort || arm_accept_s) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (xfer_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // Burst buffer; contents are intentionally not reset.
  always_ff @(posedge clock_in) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= adc_data;
  end

  assign rd_data  = rd_valid_r ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

`ifdef ADC_BURST_CAPTURE_TIMEOUT_EN
  logic [WD_W-1:0] wd_r;
  logic            timeout_r;

  // A coincident strobe counts as progress, so it wins over expiry.
  assign wd_expire_s = (state_r == CAPTURE) && !strobe_s && !abort &&
                       (wd_r == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and sticky timeout flag (cleared only by an accepted arm).
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      wd_r      <= {WD_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (abort || strobe_s || (state_r != CAPTURE)) wd_r <= {WD_W{1'b0}};
      else                                            wd_r <= wd_r + WD_W'(1);
      if (arm_accept_s)     timeout_r <= 1'b0;
      else if (wd_expire_s) timeout_r <= 1'b1;
    end
  end

  assign timeout = timeout_r;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expire_s = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_adc_burst_capture.sv
// Self-checking bench for adc_burst_capture: scenario table plus corner-case sequences,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_adc_burst_capture;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;
  localparam int BOUND   = 400;
`ifdef ADC_BURST_CAPTURE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clock_in   = 1'b0;
  logic              reset      = 1'b0;
  logic              sample_clk = 1'b0;
  logic [DATA_W-1:0] adc_data   = 8'h00;
  logic              arm        = 1'b0;
  logic              trigger    = 1'b0;
  logic              abort      = 1'b0;
  logic              rd_ready   = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              timeout;

  adc_burst_capture #(
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .sample_clk (sample_clk),
    .adc_data   (adc_data),
    .arm        (arm),
    .trigger    (trigger),
    .abort      (abort),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int         at_edge;
    logic [7:0] val;
  } strobe_t;

  typedef struct {
    bit do_arm;
    int trig_delay;
    int rmode;
    int abort_after;
    int exp_words;
    int exp_done;
  } scen_t;

  // Behavioural model: pending strobes, captured words, and a coarse mode (0 idle,1 armed,2 capture,3 readout).
  strobe_t    sq[$];
  logic [7:0] mbuf[$];
  logic [7:0] rx[$];
  int         m_mode, m_rd, m_last_evt;
  bit         m_done, m_to;

  int         ec, phase, ready_mode, words, done_cnt;
  int         checks, failures;
  bit         sc_en;
  logic [7:0] next_val;
  scen_t      tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=0x%0h want=0x%0h", name, ec, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rd = 0; m_done = 1'b0; m_to = 1'b0; m_last_evt = 0;
    mbuf.delete();
    sq.delete();
  endtask

  task automatic model_edge(input int e);
    bit         stb;
    logic [7:0] sv;
    stb = 1'b0;
    sv  = 8'h00;
    if (sq.size() > 0 && sq[0].at_edge == e) begin
      stb = 1'b1;
      sv  = sq[0].val;
      sq.delete(0);
    end
    m_done = 1'b0;
    if (abort) begin
      m_mode = 0;
      m_rd   = 0;
    end else begin
      case (m_mode)
        0: if (arm) begin m_mode = 1; mbuf.delete(); m_to = 1'b0; end
        1: if (trigger) begin m_mode = 2; m_last_evt = e; end
        2: begin
          if (stb) begin
            mbuf.push_back(sv);
            m_last_evt = e;
            if (mbuf.size() == DEPTH) begin m_mode = 3; m_rd = 0; end
          end else if (TO_EN && (e - m_last_evt >= TIMEOUT)) begin
            m_mode = 0;
            m_to   = 1'b1;
          end
        end
        3: if (rd_ready) begin
          m_rd++;
          if (m_rd == DEPTH) begin m_mode = 0; m_done = 1'b1; end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  // One clock: drive rd_ready, advance model and DUT, move sample_clk, compare.
  task automatic cycle();
    logic [7:0] exp_d;
    logic [7:0] act_d;
    case (ready_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      2:       rd_ready = 1'($urandom_range(0, 1));
      default: rd_ready = 1'b0;
    endcase
    if (rd_valid && rd_ready) begin
      words++;
      rx.push_back(rd_data);
    end
    model_edge(ec + 1);
    @(posedge clock_in);
    ec++;
    #1;
    if (done) done_cnt++;
    phase = (phase + 1) % 10;
    if (phase == 0 && sc_en) begin
      sample_clk = 1'b1;
      adc_data   = next_val;
      next_val   = next_val + 8'h01;
      sq.push_back('{at_edge: ec + 3, val: adc_data});
    end else if (phase == 5) begin
      sample_clk = 1'b0;
    end
    exp_d = (m_mode == 3) ? mbuf[m_rd] : 8'h00;
    act_d = (m_mode == 3) ? rd_data : 8'h00;
    check("cycle_outputs",
          {20'd0, busy, rd_valid, done, timeout, act_d},
          {20'd0, (m_mode != 0), (m_mode == 3), m_done, m_to, exp_d});
  endtask

  task automatic run_scen(input scen_t s);
    int n;
    words = 0; done_cnt = 0; rx.delete();
    ready_mode = s.rmode;
    if (!s.do_arm) begin
      trigger = 1'b1;
      repeat (100) cycle();
      trigger = 1'b0;
    end else begin
      arm = 1'b1; cycle(); arm = 1'b0;
      repeat (s.trig_delay - 1) cycle();
      trigger = 1'b1; cycle(); trigger = 1'b0;
      n = 0;
      while (m_mode != 0 && n < BOUND) begin
        if (s.abort_after != 0 && m_mode == 2 && mbuf.size() == s.abort_after) abort = 1'b1;
        cycle();
        abort = 1'b0;
        n++;
      end
      check("burst_bound", 32'(n < BOUND), 32'd1);
    end
    ready_mode = 0;
    repeat (3) cycle();
    check("words_read", words, s.exp_words);
    check("done_pulses", done_cnt, s.exp_done);
    if (rx.size() == DEPTH) begin
      for (int i = 1; i < DEPTH; i++) check("consecutive", rx[i], 8'(rx[0] + i));
    end
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; ec = 0; phase = 9; sc_en = 1'b1;
    next_val = 8'h10; ready_mode = 0; words = 0; done_cnt = 0;
    model_reset();

    #1 reset = 1'b1;
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_timeout", timeout, 1'b0);
    check("reset_rd_data", rd_data, 8'h00);
    @(posedge clock_in);
    @(posedge clock_in);
    #1 reset = 1'b0;

    tbl[0] = '{1'b1, 2, 0, 0, 4, 1};
    tbl[1] = '{1'b1, 2, 1, 0, 4, 1};
    tbl[2] = '{1'b0, 0, 0, 0, 0, 0};
    tbl[3] = '{1'b1, 2, 0, 2, 0, 0};
    tbl[4] = '{1'b1, 3, 2, 0, 4, 1};
    for (int i = 5; i < 8; i++) tbl[i] = '{1'b1, int'($urandom_range(1, 8)), 2, 0, 4, 1};
    for (int i = 0; i < 8; i++) run_scen(tbl[i]);

    // Asynchronous reset while a burst is being offered.
    ready_mode = 3;
    arm = 1'b1; cycle(); arm = 1'b0;
    cycle();
    trigger = 1'b1; cycle(); trigger = 1'b0;
    n = 0;
    while (m_mode != 3 && n < BOUND) begin cycle(); n++; end
    check("readout_bound", 32'(n < BOUND), 32'd1);
    repeat (3) cycle();
    @(negedge clock_in);
    reset = 1'b1;
    #1;
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_rd_valid", rd_valid, 1'b0);
    check("async_reset_done", done, 1'b0);
    check("async_reset_timeout", timeout, 1'b0);
    check("async_reset_rd_data", rd_data, 8'h00);
    sample_clk = 1'b0;
    model_reset();
    phase = 9;
    @(posedge clock_in);
    @(posedge clock_in);
    #1 reset = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      trigger = 1'($urandom_range(0, 1));
      cycle();
    end
    trigger = 1'b0;
    check("idle_after_reset", busy, 1'b0);
    run_scen(tbl[0]);

`ifdef ADC_BURST_CAPTURE_TIMEOUT_EN
    // Stall the sample clock after one capture and let the watchdog fire.
    ready_mode = 0;
    arm = 1'b1; cycle(); arm = 1'b0;
    trigger = 1'b1; cycle(); trigger = 1'b0;
    n = 0;
    while (mbuf.size() < 1 && n < BOUND) begin cycle(); n++; end
    sc_en = 1'b0;
    check("first_capture_bound", 32'(n < BOUND), 32'd1);
    n = 0;
    while (m_mode != 0 && n < BOUND) begin cycle(); n++; end
    check("watchdog_bound", 32'(n < BOUND), 32'd1);
    check("timeout_set", timeout, 1'b1);
    check("timeout_idle", busy, 1'b0);
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (4) cycle();
    check("timeout_sticky", timeout, 1'b1);
    sc_en = 1'b1;
    arm = 1'b1; cycle(); arm = 1'b0;
    check("timeout_cleared_by_arm", timeout, 1'b0);
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (3) cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
